aes_decrypt_feeder: RTL and testbench
=====================================

# aes_decrypt_feeder

Upstream feeder for the AES decrypt core. It accepts ciphertext as a stream of 32-bit words over a valid/ready handshake and assembles each group of four words into a 128-bit block. It then presents the block and key to the decrypt core and sequences the core's start pulse and round-enable for the full round count. Finally it captures the core's 128-bit result and offers it downstream as a plaintext block with its own valid/ready handshake.

## Interface
Parameters:
- NK, default 4: key length in 32-bit words; width of `key` and `core_key` is NK*32.
- NR, default 10: round count of the attached core; core latency LAT = NR+2 enabled cycles.

Ports:
- clk, input, 1: single clock, all state on posedge.
- rst, input, 1: reset, asynchronous, active-high.
- key, input, NK*32: cipher key; sampled when the first word of a block is accepted.
- in_word, input, 32: ciphertext word; first word of a block maps to bits 127:96, fourth word to bits 31:0.
- in_valid, input, 1: `in_word` valid.
- in_ready, output, 1: feeder can accept `in_word`.
- core_data, output, 128: assembled ciphertext block to the core (registered).
- core_key, output, NK*32: latched key to the core (registered).
- core_start, output, 1: one-cycle pulse; core reloads key/data and zeroes its round counter.
- core_active, output, 1: core round-enable.
- core_out, input, 128: core result.
- pt_data, output, 128: captured plaintext block.
- pt_valid, output, 1: `pt_data` valid.
- pt_ready, input, 1: downstream accepts `pt_data`.
- busy, output, 1: high in RUN or HOLD.

## Operation
- The FSM has three states: FILL, RUN and HOLD. Reset state is FILL.
- Reset values: word index 0, cycle counter 0, `core_data` 0, `core_key` 0, `pt_data` 0, `core_start` 0, `core_active` 0, `pt_valid` 0, `busy` 0. `in_ready` is 1 in FILL after reset.
- FILL:
  - `in_ready`=1. Each `in_valid && in_ready` edge writes `in_word` into slot [127-32*idx -: 32] of `core_data` and increments the 2-bit index.
  - `key` is latched into `core_key` on the edge that accepts idx 0.
  - When idx 3 is accepted, the index wraps to 0 and the FSM goes to RUN.
- RUN:
  - A 5-bit counter `cnt` starts at 0.
  - `core_start`=1 while cnt==0.
  - `core_active`=1 for cnt=0..LAT-1.
  - At cnt==LAT, `core_active` is 0 and `core_out` is captured into `pt_data`. On the same edge `pt_valid` is set and the FSM goes to HOLD.
  - `core_data` and `core_key` are held stable throughout RUN.
- HOLD:
  - `pt_valid`=1 and `pt_data` is stable until `pt_valid && pt_ready`.
  - On that edge `pt_valid` clears and the FSM goes to FILL, or directly to RUN if a prefetched block is complete (see Configuration).
- Simultaneous events:
  - `in_valid` is ignored whenever `in_ready`=0.
  - `pt_ready` is ignored while `pt_valid`=0.
- Reset mid-operation: asserting `rst` in any state aborts immediately. All outputs take their reset values asynchronously and any partial block is discarded.

## Timing
- `in_ready` is a function of state only; it has no combinational path from `in_valid`.
- Latency: let the fourth word be accepted at edge E.
  - `core_start` is high during cycle E..E+1.
  - `core_active` is high for cycles E..E+LAT.
  - `pt_valid` rises after edge E+LAT+1, which is E+13 for NR=10.
- Throughput without prefetch: 4 + LAT + 1 + 1 cycles per block minimum (pt_ready held high).
- `pt_valid` falls on the edge after the handshake. There is no combinational path from `pt_ready` to `pt_valid`.

## Configuration
- Macro `AES_FEED_PREFETCH_EN`.
- Defined:
  - A second 128-bit staging buffer and key latch are added.
  - `in_ready`=1 in RUN and HOLD until the staging buffer holds 4 words.
  - On the HOLD handshake with staging full, the staging buffer moves to `core_data`/`core_key` and the FSM enters RUN directly. With staging partial, the contents move and the FSM goes to FILL at the matching idx.
  - Throughput becomes LAT + 2 cycles per block.
- Undefined:
  - `in_ready`=0 in RUN and HOLD.
  - No staging logic exists.

## Test plan
- Single block: key=000102030405060708090a0b0c0d0e0f; words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; pt_ready=1 → core_data=69c4e0d86a7b0430d8cdb78070b4c55a, `core_start` pulses once, `core_active` is high 12 cycles, and `pt_valid` rises 13 cycles after the last accept with pt_data=00112233445566778899aabbccddeeff.
- Bubbles: in_valid toggled 1/0 on alternate cycles across the same four words → identical core_data and result; idx advances only on handshakes.
- Backpressure: pt_ready=0 for 20 cycles after pt_valid → pt_data stable, pt_valid held, in_ready=0 (macro off); release → pt_valid falls next edge and in_ready=1.
- Reset mid-RUN: rst pulsed at cnt==5 → core_active=0, busy=0, pt_valid=0, core_data=0 immediately; a fresh block afterwards decrypts correctly.
- Prefetch (macro on): two back-to-back blocks with pt_ready=1 → second block's words are accepted during RUN of the first; second pt_valid rises LAT+2 cycles after the first handshake.

Source files
------------

// File: rtl/aes_decrypt_feeder.sv
// aes_decrypt_feeder
//
// Feeds the AES decrypt core. The block collects four 32-bit ciphertext words
// into a 128-bit block and drives that block and the key into the core. It
// sequences the core's start pulse and round-enable for the core latency.
// It then captures the core result and offers it downstream as plaintext.
//
// Ports:
//   clk, rst            single clock; asynchronous active-high reset
//   key                 cipher key, sampled with the first word of a block
//   in_word/in_valid/in_ready   ciphertext word stream (first word -> 127:96)
//   core_data, core_key assembled block and latched key to the core
//   core_start          one-cycle pulse: core reloads and zeroes its rounds
//   core_active         core round-enable, high for LAT = NR+2 cycles
//   core_out            core result, captured when the round count completes
//   pt_data/pt_valid/pt_ready   plaintext block handshake
//   busy                high while a block is running or waiting downstream
//
// Optional feature: define AES_FEED_PREFETCH_EN to add a second staging
// buffer. With it, the next block can be collected while the current one
// runs or waits.

module aes_decrypt_feeder #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NK*32-1:0] key,
    input  logic [31:0]      in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     core_data,
    output logic [NK*32-1:0] core_key,
    output logic             core_start,
    output logic             core_active,
    input  logic [127:0]     core_out,
    output logic [127:0]     pt_data,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic             busy
);

    localparam int         LAT     = NR + 2;
    localparam logic [4:0] LAT_CNT = 5'(LAT);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Place a 32-bit word into one of the four block slots (slot 0 = MSW).
    function automatic logic [127:0] put_word(input logic [127:0] blk,
                                              input logic [1:0]   slot,
                                              input logic [31:0]  w);
        logic [127:0] r;
        r = blk;
        case (slot)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            2'd3:    r[31:0]   = w;
            default: r = blk;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [127:0]       core_data_q, core_data_d;
    logic [NK*32-1:0]   core_key_q, core_key_d;
    logic [127:0]       pt_data_q, pt_data_d;
    logic               pt_valid_q, pt_valid_d;
    logic               core_start_q, core_start_d;
    logic               core_active_q, core_active_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    logic               accept_s;
    logic               hs_s;

`ifdef AES_FEED_PREFETCH_EN
    logic [127:0]       stg_data_q, stg_data_d, stg_data_acc_s;
    logic [NK*32-1:0]   stg_key_q, stg_key_d, stg_key_acc_s;
    logic [2:0]         stg_cnt_q, stg_cnt_d, stg_cnt_acc_s;
`endif

    // in_ready is a flop decoded from the next state, so in_valid never
    // reaches it combinationally.
    assign accept_s = in_valid && in_ready_q;
    assign hs_s     = pt_valid_q && pt_ready;

`ifdef AES_FEED_PREFETCH_EN
    // Staging buffer contents including any word accepted this cycle.
    always_comb begin
        stg_data_acc_s = stg_data_q;
        stg_key_acc_s  = stg_key_q;
        stg_cnt_acc_s  = stg_cnt_q;
        if (accept_s && (state_q != S_FILL)) begin
            stg_data_acc_s = put_word(stg_data_q, stg_cnt_q[1:0], in_word);
            if (stg_cnt_q == 3'd0) begin
                stg_key_acc_s = key;
            end else begin
                stg_key_acc_s = stg_key_q;
            end
            stg_cnt_acc_s = stg_cnt_q + 3'd1;
        end else begin
            stg_cnt_acc_s = stg_cnt_q;
        end
    end
`endif

    // Next-state logic. All output flops are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        core_data_d = core_data_q;
        core_key_d  = core_key_q;
        pt_data_d   = pt_data_q;
        pt_valid_d  = pt_valid_q;
`ifdef AES_FEED_PREFETCH_EN
        stg_data_d  = stg_data_acc_s;
        stg_key_d   = stg_key_acc_s;
        stg_cnt_d   = stg_cnt_acc_s;
`endif
        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    core_data_d = put_word(core_data_q, idx_q, in_word);
                    if (idx_q == 2'd0) begin
                        core_key_d = key;
                    end else begin
                        core_key_d = core_key_q;
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_RUN;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_RUN: begin
                if (cnt_q == LAT_CNT) begin
                    pt_data_d  = core_out;
                    pt_valid_d = 1'b1;
                    state_d    = S_HOLD;
                    cnt_d      = 5'd0;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = S_RUN;
                end
            end
            S_HOLD: begin
                if (hs_s) begin
                    pt_valid_d = 1'b0;
`ifdef AES_FEED_PREFETCH_EN
                    stg_cnt_d = 3'd0;
                    if (stg_cnt_acc_s == 3'd4) begin
                        // A full prefetched block starts its run right away.
                        core_data_d = stg_data_acc_s;
                        core_key_d  = stg_key_acc_s;
                        idx_d       = 2'd0;
                        cnt_d       = 5'd0;
                        state_d     = S_RUN;
                    end else if (stg_cnt_acc_s != 3'd0) begin
                        // A partial block continues filling where it stopped.
                        core_data_d = stg_data_acc_s;
                        core_key_d  = stg_key_acc_s;
                        idx_d       = stg_cnt_acc_s[1:0];
                        state_d     = S_FILL;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = S_FILL;
                    end
`else
                    idx_d   = 2'd0;
                    state_d = S_FILL;
`endif
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d    = S_FILL;
                idx_d      = 2'd0;
                cnt_d      = 5'd0;
                pt_valid_d = 1'b0;
            end
        endcase

        core_start_d  = (state_d == S_RUN) && (cnt_d == 5'd0);
        core_active_d = (state_d == S_RUN) && (cnt_d < LAT_CNT);
        busy_d        = (state_d != S_FILL);
`ifdef AES_FEED_PREFETCH_EN
        in_ready_d    = (state_d == S_FILL) || (stg_cnt_d != 3'd4);
`else
        in_ready_d    = (state_d == S_FILL);
`endif
    end

    // Main state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FILL;
            idx_q         <= 2'd0;
            cnt_q         <= 5'd0;
            core_data_q   <= 128'd0;
            core_key_q    <= '0;
            pt_data_q     <= 128'd0;
            pt_valid_q    <= 1'b0;
            core_start_q  <= 1'b0;
            core_active_q <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            core_data_q   <= core_data_d;
            core_key_q    <= core_key_d;
            pt_data_q     <= pt_data_d;
            pt_valid_q    <= pt_valid_d;
            core_start_q  <= core_start_d;
            core_active_q <= core_active_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
        end
    end

`ifdef AES_FEED_PREFETCH_EN
    // Staging buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_data_q <= 128'd0;
            stg_key_q  <= '0;
            stg_cnt_q  <= 3'd0;
        end else begin
            stg_data_q <= stg_data_d;
            stg_key_q  <= stg_key_d;
            stg_cnt_q  <= stg_cnt_d;
        end
    end
`endif

    assign in_ready    = in_ready_q;
    assign core_data   = core_data_q;
    assign core_key    = core_key_q;
    assign core_start  = core_start_q;
    assign core_active = core_active_q;
    assign pt_data     = pt_data_q;
    assign pt_valid    = pt_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_aes_decrypt_feeder.sv
// Testbench for aes_decrypt_feeder. A behavioural core stand-in returns a
// known plaintext for the reference vector and a keyed scramble otherwise.
// It returns garbage until exactly LAT enabled cycles have passed since the
// start pulse.
module tb_aes_decrypt_feeder;

    localparam int NK  = 4;
    localparam int NR  = 10;
    localparam int LAT = NR + 2;
`ifdef AES_FEED_PREFETCH_EN
    localparam int PERIOD = LAT + 2;
`else
    localparam int PERIOD = 4 + LAT + 1 + 1;
`endif

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic             clk = 1'b0;
    logic             rst;
    logic [NK*32-1:0] key;
    logic [31:0]      in_word;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     core_data;
    logic [NK*32-1:0] core_key;
    logic             core_start;
    logic             core_active;
    logic [127:0]     core_out;
    logic [127:0]     pt_data;
    logic             pt_valid;
    logic             pt_ready;
    logic             busy;

    logic pt_ready_dir;
    logic rnd_mode;
    logic rnd_bit;
    assign pt_ready = rnd_mode ? rnd_bit : pt_ready_dir;

    aes_decrypt_feeder #(.NK(NK), .NR(NR)) dut (
        .clk(clk), .rst(rst), .key(key), .in_word(in_word),
        .in_valid(in_valid), .in_ready(in_ready), .core_data(core_data),
        .core_key(core_key), .core_start(core_start),
        .core_active(core_active), .core_out(core_out), .pt_data(pt_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference decryption of the core stand-in.
    function automatic logic [127:0] ref_dec(input logic [127:0] d, input logic [127:0] k);
        if (d == CT && k == K0) return PT;
        return d ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    endfunction

    // Core stand-in: reload on start, count enabled cycles.
    logic [127:0] m_data, m_key;
    int           m_round;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= 128'd0;
            m_key   <= 128'd0;
            m_round <= 0;
        end else if (core_start) begin
            m_data  <= core_data;
            m_key   <= core_key;
            m_round <= core_active ? 1 : 0;
        end else if (core_active) begin
            m_round <= m_round + 1;
        end
    end
    assign core_out = (m_round == LAT) ? ref_dec(m_data, m_key)
                                       : ({4{32'hdeadbeef}} ^ 128'(m_round));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected plaintext and accept cycle of the fourth word.
    logic [127:0] exp_q[$];
    int           e_q[$];

    // Handshake seen at the last rising edge.
    logic hs_at_edge;
    always @(posedge clk or posedge rst) begin
        if (rst) hs_at_edge <= 1'b0;
        else     hs_at_edge <= pt_valid && pt_ready;
    end

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(negedge clk);
            rnd_bit = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented plaintext against the scoreboard.
    logic [127:0] held;
    logic         prev_v;
    int           n_start, n_act, rise_prev, rise_last, e;
    initial begin
        prev_v = 1'b0; n_start = 0; n_act = 0; held = 128'd0;
        rise_prev = -1000; rise_last = -1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0; n_start = 0; n_act = 0;
            end else begin
                if (core_start)  n_start++;
                if (core_active) n_act++;
                if (hs_at_edge) begin
                    chk("pt_valid_fall", 128'(pt_valid), 128'd0);
                end else if (prev_v) begin
                    chk("pt_valid_held", 128'(pt_valid), 128'd1);
                    chk("pt_data_stable", pt_data, held);
                end else if (pt_valid) begin
                    chk("start_pulses", 128'(n_start), 128'd1);
                    chk("active_cycles", 128'(n_act), 128'(LAT));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block", 128'(pt_valid), 128'd0);
                    end else begin
                        chk("pt_data", pt_data, exp_q.pop_front());
                    end
                    if (e_q.size() != 0) begin
                        e = e_q.pop_front();
`ifndef AES_FEED_PREFETCH_EN
                        chk("latency", 128'(cyc - e), 128'(LAT + 1));
`endif
                    end
                    rise_prev = rise_last;
                    rise_last = cyc;
                    n_start = 0;
                    n_act = 0;
                    held = pt_data;
                end
`ifndef AES_FEED_PREFETCH_EN
                chk("in_ready_vs_busy", 128'(in_ready), 128'(!busy));
`endif
                prev_v = pt_valid;
            end
        end
    end

    // Send one block; mode 0 = continuous, 1 = alternate bubbles, 2 = random.
    task automatic send(input logic [127:0] blk, input logic [127:0] k, input int mode);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        while (i < 4) begin
            @(negedge clk);
            if ((mode == 1 && budget % 2 == 1) || (mode == 2 && $urandom_range(0, 1) == 0)) begin
                in_valid = 1'b0;
                in_word  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_word  = blk[127 - 32*i -: 32];
            end
            key = (i == 0) ? k : {$urandom, $urandom, $urandom, $urandom};
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
            budget++;
            if (budget > 400) begin
                chk("accept_timeout", 128'(i), 128'd4);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (i == 4) begin
            exp_q.push_back(ref_dec(blk, k));
            e_q.push_back(cyc);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(exp_q.size() == 0 && !pt_valid && !busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            chk("drain_timeout", 128'(exp_q.size()), 128'd0);
            exp_q.delete();
            e_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_word = 32'd0; key = '0;
        pt_ready_dir = 1'b1; rnd_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_data", core_data, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_pt_data", pt_data, 128'd0);
        chk("rst_flags", {124'd0, core_start, core_active, pt_valid, busy}, 128'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // Reference vector, continuous input.
        send(CT, K0, 0);
        chk("single_core_data", core_data, CT);
        chk("single_core_key", core_key, K0);
        chk("single_busy", 128'(busy), 128'd1);
        wait_drain();

        // Same words with alternating bubbles.
        send(CT, K0, 1);
        chk("bubble_core_data", core_data, CT);
        chk("bubble_core_key", core_key, K0);
        wait_drain();

        // Backpressure for 20 cycles.
        pt_ready_dir = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
        n = 0;
        while (!pt_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_pt_valid_seen", 128'(pt_valid), 128'd1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_pt_valid", 128'(pt_valid), 128'd1);
`ifndef AES_FEED_PREFETCH_EN
            chk("bp_in_ready", 128'(in_ready), 128'd0);
`endif
        end
        pt_ready_dir = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(pt_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready), 128'd1);
        wait_drain();

        // Reset at cnt == 5.
        send(CT ^ 128'h1, K0, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        e_q.delete();
        #1;
        chk("midrst_core_data", core_data, 128'd0);
        chk("midrst_flags", {124'd0, core_start, core_active, pt_valid, busy}, 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        send(CT, K0, 0);
        chk("post_rst_core_data", core_data, CT);
        wait_drain();

        // Two back-to-back blocks: pt_valid rise spacing.
        send(CT, K0, 0);
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
        chk("b2b_busy", 128'(busy), 128'd1);
        wait_drain();
        chk("b2b_period", 128'(rise_last - rise_prev), 128'(PERIOD));

        // Randomized blocks with random bubbles and backpressure.
        rnd_mode = 1'b1;
        for (int b = 0; b < 30; b++) begin
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2);
        end
        wait_drain();
        rnd_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
